seq_det_ctrl: RTL and testbench
===============================

Name: seq_det_ctrl

Overview:
- Test-sequencing controller for the Moore four-in-a-row sequence detector: 4 consecutive 0s → out=1; 4 consecutive 1s → out=1.
- Loads a parallel pattern and resets the detector. Feeds the pattern to the detector serially, MSB first, one bit per clk.
- Samples the detector output after every bit and reports a per-bit hit map and a hit count, using a start/busy/done handshake.
- Sits between the board switches/keys and the detector instance on the same clk.

Parameters:
- PAT_W, 16: pattern length in bits; legal range ≥4.
- CNT_W, 5: hit counter width; must satisfy 2^CNT_W > PAT_W.

Ports:
- clk  input  1  system clock; the detector shares this clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  begin a run; sampled only in IDLE.
- abort  input  1  cancel a run in progress.
- pattern  input  PAT_W  bits to feed; captured on accepted start.
- det_out  input  1  detector output (Moore, reflects the detector's current state).
- det_in  output  1  serial bit to the detector's in.
- det_rst  output  1  synchronous active-high reset to the detector.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse at end of a completed run.
- hit_vec  output  PAT_W  bit (PAT_W-1-j) = detector out after pattern bit j.
- hit_cnt  output  CNT_W  number of 1s in hit_vec.

Behaviour:
- States: IDLE, SHIFT, DRAIN, DONE.
- Reset values: state=IDLE, det_rst=1, det_in=0, busy=0, done=0, hit_vec=0, hit_cnt=0, bit index=0.
- det_rst=1 in IDLE and DONE; 0 in SHIFT and DRAIN. The detector is therefore held in its initial state whenever no run is active.
- IDLE, start=1 and abort=0: capture pattern into a shift register, clear hit_vec and hit_cnt, index←0, go to SHIFT. Otherwise stay.
- SHIFT: det_in = shift register MSB (pattern bit j in cycle j). The register shifts left each cycle.
- In SHIFT cycle j≥1, det_out reflects bits 0..j-1. At the clock edge, record hit_vec[PAT_W-j] ← det_out and add det_out to hit_cnt.
- After SHIFT cycle PAT_W-1, go to DRAIN.
- DRAIN: det_in=0. Record hit_vec[0] ← det_out (result after the last bit), update hit_cnt, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- hit_vec and hit_cnt hold from DONE until the next accepted start.
- busy=1 in SHIFT and DRAIN only.
- Timing: start sampled at edge E; busy is high for PAT_W+1 cycles (17 by default); done is high in cycle E+PAT_W+2.
- start while busy or in DONE: ignored; it is not queued.
- abort=1 in SHIFT or DRAIN: next state IDLE; hit_vec and hit_cnt cleared; no done pulse; det_rst rises next cycle.
- abort=1 in IDLE or DONE: no effect, except that it blocks start in the same cycle (abort wins).
- reset asserted mid-run: immediate return to reset values, including det_rst=1.
- hit_cnt never exceeds PAT_W; no wrap is possible given the CNT_W constraint.

Decomposition:
- Shared package: state enum (IDLE, SHIFT, DRAIN, DONE); default PAT_W; function giving CNT_W for a PAT_W.
- One natural sub-module: piso_shreg, a parallel-load, shift-left register with MSB out, load and shift enables, and async active-low reset.
- The bench instantiates the existing detector alongside seq_det_ctrl, connected on the same clk.

Test Plan:
- pattern=16'h0F00, start pulse → busy 17 cycles, done pulse, hit_vec=16'h111F, hit_cnt=13? No: hit_cnt=7 (hits after bits j=3,7,11,12,13,14,15).
- pattern=16'hAAAA → hit_vec=16'h0000, hit_cnt=0, done still pulses after 17 busy cycles.
- pattern=16'h0000, then a second run with 16'hFFFF → each run gives hit_vec=16'h1FFF, hit_cnt=13. The second run shows no carry-over of detector state because det_rst was high between runs.
- start pulsed again at SHIFT index 5 during a 16'h0F00 run → ignored; results identical to the first scenario.
- abort at SHIFT index 8 → busy falls next cycle, no done, hit_vec=0, hit_cnt=0, det_rst=1. A following start with 16'hFFFF gives hit_cnt=13.
- reset driven low at SHIFT index 10 → all outputs return to reset values asynchronously, det_rst=1. After release, start with 16'h0F00 gives 16'h111F and 7.

Source files
------------

// File: rtl/seq_det_ctrl_pkg.sv
// Shared definitions for the sequence-detector test controller.
package seq_det_ctrl_pkg;

  localparam int PAT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Hit counter must hold the value PAT_W itself.
  function automatic int cnt_w_for(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_det.sv
// Moore four-in-a-row detector: out=1 after four equal consecutive input bits.
module seq_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam logic [3:0] S_INIT = 4'd0;
  localparam logic [3:0] S_Z1   = 4'd1;
  localparam logic [3:0] S_Z2   = 4'd2;
  localparam logic [3:0] S_Z3   = 4'd3;
  localparam logic [3:0] S_Z4   = 4'd4;
  localparam logic [3:0] S_O1   = 4'd5;
  localparam logic [3:0] S_O2   = 4'd6;
  localparam logic [3:0] S_O3   = 4'd7;
  localparam logic [3:0] S_O4   = 4'd8;

  logic [3:0] state;
  logic [3:0] nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= nxt;
  end

  always_comb begin
    nxt = S_INIT;
    case (state)
      S_Z1:    nxt = din ? S_O1 : S_Z2;
      S_Z2:    nxt = din ? S_O1 : S_Z3;
      S_Z3:    nxt = din ? S_O1 : S_Z4;
      S_Z4:    nxt = din ? S_O1 : S_Z4;
      S_O1:    nxt = din ? S_O2 : S_Z1;
      S_O2:    nxt = din ? S_O3 : S_Z1;
      S_O3:    nxt = din ? S_O4 : S_Z1;
      S_O4:    nxt = din ? S_O4 : S_Z1;
      default: nxt = din ? S_O1 : S_Z1;
    endcase
  end

  assign dout = (state == S_Z4) || (state == S_O4);

endmodule

// File: rtl/seq_det_ctrl_piso_shreg.sv
// Parallel-load, shift-left register presenting its MSB as the serial output.
module piso_shreg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] par,
  output logic         msb
);

  logic [W-1:0] data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     data <= '0;
    else if (load)  data <= par;
    else if (shift) data <= {data[W-2:0], 1'b0};
  end

  assign msb = data[W-1];

endmodule

// File: rtl/seq_det_ctrl.sv
// Feeds a captured pattern MSB-first into the detector and collects a per-bit
// hit map and hit count, with a start/busy/done handshake.
module seq_det_ctrl
  import seq_det_ctrl_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = cnt_w_for(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic             det_out,
  output logic             det_in,
  output logic             det_rst,
  output logic             busy,
  output logic             done,
  output logic [PAT_W-1:0] hit_vec,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int               IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(PAT_W - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             sreg_msb;

  assign accept = (state == ST_IDLE) && start && !abort;

  piso_shreg #(.W(PAT_W)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (state == ST_SHIFT),
    .par   (pattern),
    .msb   (sreg_msb)
  );

  assign det_in  = (state == ST_SHIFT) ? sreg_msb : 1'b0;
  assign det_rst = (state == ST_IDLE) || (state == ST_DONE);
  assign busy    = (state == ST_SHIFT) || (state == ST_DRAIN);
  assign done    = (state == ST_DONE);

  // Samples arrive in bit order MSB-first, so shifting each one in at the LSB
  // leaves the first sample in bit PAT_W-1 and the drain sample in bit 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      hit_vec <= '0;
      hit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_SHIFT;
            idx     <= '0;
            hit_vec <= '0;
            hit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            state   <= ST_IDLE;
            idx     <= '0;
            hit_vec <= '0;
            hit_cnt <= '0;
          end else begin
            if (idx != '0) begin
              hit_vec <= {hit_vec[PAT_W-2:0], det_out};
              hit_cnt <= hit_cnt + CNT_W'(det_out);
            end
            if (idx == LAST) begin
              state <= ST_DRAIN;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            state   <= ST_IDLE;
            hit_vec <= '0;
            hit_cnt <= '0;
          end else begin
            state   <= ST_DONE;
            hit_vec <= {hit_vec[PAT_W-2:0], det_out};
            hit_cnt <= hit_cnt + CNT_W'(det_out);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench: controller plus detector, checked against a run-length
// model of the four-in-a-row rule.
module tb_seq_det_ctrl;

  localparam int PAT_W = 16;
  localparam int CNT_W = 5;

  logic             clk;
  logic             reset;
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic             det_out;
  logic             det_in;
  logic             det_rst;
  logic             busy;
  logic             done;
  logic [PAT_W-1:0] hit_vec;
  logic [CNT_W-1:0] hit_cnt;

  int errors = 0;
  int checks = 0;

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .pattern (pattern),
    .det_out (det_out),
    .det_in  (det_in),
    .det_rst (det_rst),
    .busy    (busy),
    .done    (done),
    .hit_vec (hit_vec),
    .hit_cnt (hit_cnt)
  );

  seq_det u_det (
    .clk  (clk),
    .rst  (det_rst),
    .din  (det_in),
    .dout (det_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hit after bit j when the run of equal bits ending at j is at least four long.
  function automatic logic [PAT_W-1:0] model_vec(input logic [PAT_W-1:0] pat);
    logic [PAT_W-1:0] v;
    int run;
    v   = '0;
    run = 0;
    for (int j = 0; j < PAT_W; j++) begin
      if (j > 0 && pat[PAT_W-1-j] == pat[PAT_W-j]) run++;
      else run = 1;
      v[PAT_W-1-j] = (run >= 4);
    end
    return v;
  endfunction

  function automatic int model_cnt(input logic [PAT_W-1:0] pat);
    logic [PAT_W-1:0] v;
    int n;
    v = model_vec(pat);
    n = 0;
    for (int i = 0; i < PAT_W; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one pattern from IDLE and reports what was observed; no checking here.
  task automatic do_run(input logic [PAT_W-1:0] pat, input int restart_at,
                        output int busy_cycles, output int done_cycles,
                        output int done_off, output int in_bad, output int rst_bad,
                        output logic [PAT_W-1:0] vec, output logic [CNT_W-1:0] cnt);
    busy_cycles = 0;
    done_cycles = 0;
    done_off    = -1;
    in_bad      = 0;
    rst_bad     = 0;
    vec         = 'x;
    cnt         = 'x;
    pattern     = pat;
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (busy) busy_cycles++;
      if (done) begin
        done_cycles++;
        if (done_off < 0) done_off = cyc;
      end
      if (det_rst !== ~busy) rst_bad++;
      if (cyc <= PAT_W && det_in !== pat[PAT_W-cyc]) in_bad++;
      if (cyc == PAT_W + 1 && det_in !== 1'b0) in_bad++;
      if (done_off >= 0 && cyc == done_off + 1) begin
        vec = hit_vec;
        cnt = hit_cnt;
        break;
      end
      if (cyc == restart_at + 1) begin
        start   = 1'b1;
        pattern = ~pat;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    pattern = '0;
    #1 reset = 1'b0;
    tick();
    tick();
    checks++; if (det_rst !== 1'b1) begin errors++; $display("[TB] FAIL reset_det_rst: got %b expected 1", det_rst); end
    checks++; if (det_in !== 1'b0) begin errors++; $display("[TB] FAIL reset_det_in: got %b expected 0", det_in); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (hit_vec !== '0) begin errors++; $display("[TB] FAIL reset_hit_vec: got %h expected 0", hit_vec); end
    checks++; if (hit_cnt !== '0) begin errors++; $display("[TB] FAIL reset_hit_cnt: got %0d expected 0", hit_cnt); end
    reset = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_directed();
    logic [PAT_W-1:0] pats [4] = '{16'h0F00, 16'hAAAA, 16'h0000, 16'hFFFF};
    logic [PAT_W-1:0] vecs [4] = '{16'h111F, 16'h0000, 16'h1FFF, 16'h1FFF};
    int               cnts [4] = '{7, 0, 13, 13};
    int bc, dc, doff, ib, rb;
    logic [PAT_W-1:0] v;
    logic [CNT_W-1:0] c;
    for (int k = 0; k < 4; k++) begin
      do_run(pats[k], -1, bc, dc, doff, ib, rb, v, c);
      checks++; if (doff != PAT_W + 2) begin errors++; $display("[TB] FAIL dir_done_time pat=%h: got %0d expected %0d", pats[k], doff, PAT_W + 2); end
      checks++; if (bc != PAT_W + 1) begin errors++; $display("[TB] FAIL dir_busy_len pat=%h: got %0d expected %0d", pats[k], bc, PAT_W + 1); end
      checks++; if (dc != 1) begin errors++; $display("[TB] FAIL dir_done_pulses pat=%h: got %0d expected 1", pats[k], dc); end
      checks++; if (ib != 0) begin errors++; $display("[TB] FAIL dir_det_in pat=%h: got %0d bad bits expected 0", pats[k], ib); end
      checks++; if (rb != 0) begin errors++; $display("[TB] FAIL dir_det_rst pat=%h: got %0d bad cycles expected 0", pats[k], rb); end
      checks++; if (v !== vecs[k]) begin errors++; $display("[TB] FAIL dir_hit_vec pat=%h: got %h expected %h", pats[k], v, vecs[k]); end
      checks++; if (c !== CNT_W'(cnts[k])) begin errors++; $display("[TB] FAIL dir_hit_cnt pat=%h: got %0d expected %0d", pats[k], c, cnts[k]); end
    end
  endtask

  task automatic test_start_ignored();
    int bc, dc, doff, ib, rb;
    logic [PAT_W-1:0] v;
    logic [CNT_W-1:0] c;
    do_run(16'h0F00, 5, bc, dc, doff, ib, rb, v, c);
    checks++; if (doff != PAT_W + 2) begin errors++; $display("[TB] FAIL restart_done_time: got %0d expected %0d", doff, PAT_W + 2); end
    checks++; if (bc != PAT_W + 1) begin errors++; $display("[TB] FAIL restart_busy_len: got %0d expected %0d", bc, PAT_W + 1); end
    checks++; if (ib != 0) begin errors++; $display("[TB] FAIL restart_det_in: got %0d bad bits expected 0", ib); end
    checks++; if (v !== 16'h111F) begin errors++; $display("[TB] FAIL restart_hit_vec: got %h expected 111f", v); end
    checks++; if (c !== 5'd7) begin errors++; $display("[TB] FAIL restart_hit_cnt: got %0d expected 7", c); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL restart_not_queued: busy got %b expected 0", busy); end
  endtask

  task automatic test_abort();
    int seen_done, seen_busy;
    int bc, dc, doff, ib, rb;
    logic [PAT_W-1:0] v;
    logic [CNT_W-1:0] c;
    pattern = 16'h0F00;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (det_rst !== 1'b1) begin errors++; $display("[TB] FAIL abort_det_rst: got %b expected 1", det_rst); end
    checks++; if (hit_vec !== '0) begin errors++; $display("[TB] FAIL abort_hit_vec: got %h expected 0", hit_vec); end
    checks++; if (hit_cnt !== '0) begin errors++; $display("[TB] FAIL abort_hit_cnt: got %0d expected 0", hit_cnt); end
    seen_done = 0;
    seen_busy = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) seen_done++;
      if (busy) seen_busy++;
      tick();
    end
    checks++; if (seen_done != 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", seen_done); end
    checks++; if (seen_busy != 0) begin errors++; $display("[TB] FAIL abort_stays_idle: got %0d busy cycles expected 0", seen_busy); end
    do_run(16'hFFFF, -1, bc, dc, doff, ib, rb, v, c);
    checks++; if (dc != 1) begin errors++; $display("[TB] FAIL post_abort_done: got %0d expected 1", dc); end
    checks++; if (c !== 5'd13) begin errors++; $display("[TB] FAIL post_abort_hit_cnt: got %0d expected 13", c); end
    checks++; if (v !== 16'h1FFF) begin errors++; $display("[TB] FAIL post_abort_hit_vec: got %h expected 1fff", v); end
  endtask

  task automatic test_abort_blocks_start();
    pattern = 16'h0000;
    start   = 1'b1;
    abort   = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_wins_busy: got %b expected 0", busy); end
    checks++; if (det_rst !== 1'b1) begin errors++; $display("[TB] FAIL abort_wins_det_rst: got %b expected 1", det_rst); end
    tick();
  endtask

  task automatic test_reset_midrun();
    int bc, dc, doff, ib, rb;
    logic [PAT_W-1:0] v;
    logic [CNT_W-1:0] c;
    pattern = 16'h0F00;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (det_rst !== 1'b1) begin errors++; $display("[TB] FAIL midreset_det_rst: got %b expected 1", det_rst); end
    checks++; if (det_in !== 1'b0) begin errors++; $display("[TB] FAIL midreset_det_in: got %b expected 0", det_in); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done: got %b expected 0", done); end
    checks++; if (hit_vec !== '0) begin errors++; $display("[TB] FAIL midreset_hit_vec: got %h expected 0", hit_vec); end
    checks++; if (hit_cnt !== '0) begin errors++; $display("[TB] FAIL midreset_hit_cnt: got %0d expected 0", hit_cnt); end
    tick();
    reset = 1'b1;
    tick();
    do_run(16'h0F00, -1, bc, dc, doff, ib, rb, v, c);
    checks++; if (v !== 16'h111F) begin errors++; $display("[TB] FAIL post_reset_hit_vec: got %h expected 111f", v); end
    checks++; if (c !== 5'd7) begin errors++; $display("[TB] FAIL post_reset_hit_cnt: got %0d expected 7", c); end
  endtask

  task automatic test_random();
    int bc, dc, doff, ib, rb;
    logic [PAT_W-1:0] pat;
    logic [PAT_W-1:0] v;
    logic [CNT_W-1:0] c;
    for (int k = 0; k < 24; k++) begin
      pat = PAT_W'($urandom);
      // Bias some patterns toward long runs so hits are common.
      if (k % 3 == 1) pat = pat & PAT_W'($urandom) & PAT_W'($urandom);
      if (k % 3 == 2) pat = pat | PAT_W'($urandom) | PAT_W'($urandom);
      do_run(pat, -1, bc, dc, doff, ib, rb, v, c);
      checks++; if (doff != PAT_W + 2 || bc != PAT_W + 1 || dc != 1) begin errors++; $display("[TB] FAIL rnd_timing pat=%h: got done_at=%0d busy=%0d pulses=%0d expected %0d/%0d/1", pat, doff, bc, dc, PAT_W + 2, PAT_W + 1); end
      checks++; if (ib != 0) begin errors++; $display("[TB] FAIL rnd_det_in pat=%h: got %0d bad bits expected 0", pat, ib); end
      checks++; if (v !== model_vec(pat)) begin errors++; $display("[TB] FAIL rnd_hit_vec pat=%h: got %h expected %h", pat, v, model_vec(pat)); end
      checks++; if (c !== CNT_W'(model_cnt(pat))) begin errors++; $display("[TB] FAIL rnd_hit_cnt pat=%h: got %0d expected %0d", pat, c, model_cnt(pat)); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_abort();
    test_abort_blocks_start();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
